// File: rtl/dmac_write_response_tracker.sv
// dmac_write_response_tracker
// Records every write burst issued on AW and consumes the B responses in order.
// Response errors accumulate per channel. When the B response for the final
// burst of a transfer arrives, the tracker emits one completion record.
// Optional feature macro: DMAC_WR_RESP_TIMEOUT_EN adds a B-wait watchdog and
// the sticky timeout_err output.

// Protocol and configuration checks for the tracker, kept apart from the datapath.
module dmac_write_response_tracker_checker #(
  parameter int OUTSTANDING_DEPTH = 8,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input logic clk,
  input logic rst,
  input logic aw_issue_valid,
  input logic aw_issue_ready
);

  // The initiator must never hand over a burst while the tracker is full.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(aw_issue_valid && !aw_issue_ready));

  // Depth must be a power of two and at least 2. The watchdog limit must be non-zero.
  a_config_sane: assert property (@(posedge clk) disable iff (rst)
    (OUTSTANDING_DEPTH >= 2) &&
    ((OUTSTANDING_DEPTH & (OUTSTANDING_DEPTH - 1)) == 0) &&
    (TIMEOUT_CYCLES >= 1));

endmodule

module dmac_write_response_tracker #(
  parameter int CHANNEL_COUNT     = 8,
  parameter int OUTSTANDING_DEPTH = 8,
  parameter int TIMEOUT_CYCLES    = 1024,
  localparam int CH_WD  = $clog2(CHANNEL_COUNT),
  localparam int CNT_WD = $clog2(OUTSTANDING_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aw_issue_valid,
  output logic              aw_issue_ready,
  input  logic [CH_WD-1:0]  aw_issue_channel,
  input  logic              aw_issue_last,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  input  logic [1:0]        m_axi_bresp,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [CH_WD-1:0]  done_channel,
  output logic              done_error,
  output logic [CNT_WD-1:0] outstanding
`ifdef DMAC_WR_RESP_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  localparam int PTR_WD = $clog2(OUTSTANDING_DEPTH);

  // SLVERR (2'b10) and DECERR (2'b11) are failures. OKAY and EXOKAY are not.
  function automatic logic is_err_resp(input logic [1:0] resp);
    is_err_resp = resp[1];
  endfunction

  // Burst FIFO storage: one {channel, last} entry per issued burst.
  logic [CH_WD-1:0]  fifo_ch_r   [OUTSTANDING_DEPTH];
  logic              fifo_last_r [OUTSTANDING_DEPTH];
  logic [PTR_WD-1:0] wr_ptr_r;
  logic [PTR_WD-1:0] rd_ptr_r;
  logic [CNT_WD-1:0] count_r;

  // Per-channel sticky error accumulators and the completion record register.
  logic [CHANNEL_COUNT-1:0] err_r;
  logic                     done_valid_r;
  logic [CH_WD-1:0]         done_channel_r;
  logic                     done_error_r;

  logic              empty_s;
  logic              full_s;
  logic              push_s;
  logic              pop_s;
  logic              stall_s;
  logic              bready_s;
  logic [CH_WD-1:0]  head_ch_s;
  logic              head_last_s;
  logic              resp_err_s;
  logic              timeout_hit_s;

`ifdef DMAC_WR_RESP_TIMEOUT_EN
  localparam int TO_WD = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_WD-1:0] to_cnt_r;
  logic             timeout_err_r;

  // The watchdog fires once the head burst has waited the full limit.
  always_comb begin
    timeout_hit_s = 1'b0;
    if (!empty_s && (to_cnt_r == TO_WD'(TIMEOUT_CYCLES))) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Count cycles spent waiting for B. Restart on every response and while idle, then hold at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_r <= TO_WD'(0);
    end else if (empty_s || pop_s) begin
      to_cnt_r <= TO_WD'(0);
    end else if (!timeout_hit_s) begin
      to_cnt_r <= to_cnt_r + TO_WD'(1);
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err_r <= 1'b0;
    end else if (timeout_hit_s) begin
      timeout_err_r <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Handshake decode. aw_issue_ready looks only at the registered count, never at a same-cycle pop.
  always_comb begin
    empty_s     = (count_r == CNT_WD'(0));
    full_s      = (count_r == CNT_WD'(OUTSTANDING_DEPTH));
    head_ch_s   = fifo_ch_r[rd_ptr_r];
    head_last_s = fifo_last_r[rd_ptr_r];
    // A final-burst response cannot be taken while the record register still holds an unaccepted record.
    stall_s     = head_last_s && done_valid_r && !done_ready;
    bready_s    = !empty_s && !stall_s;
    push_s      = aw_issue_valid && !full_s;
    pop_s       = m_axi_bvalid && bready_s;
    // A timed-out head counts as failed, even if its response arrives late.
    resp_err_s  = is_err_resp(m_axi_bresp) | timeout_hit_s;
  end

  // FIFO pointers, entry writes and the occupancy count. Push and pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_WD'(0);
      rd_ptr_r <= PTR_WD'(0);
      count_r  <= CNT_WD'(0);
      for (int i = 0; i < OUTSTANDING_DEPTH; i++) begin
        fifo_ch_r[i]   <= CH_WD'(0);
        fifo_last_r[i] <= 1'b0;
      end
    end else begin
      if (push_s) begin
        fifo_ch_r[wr_ptr_r]   <= aw_issue_channel;
        fifo_last_r[wr_ptr_r] <= aw_issue_last;
        wr_ptr_r              <= wr_ptr_r + PTR_WD'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_WD'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_WD'(1);
        2'b01:   count_r <= count_r - CNT_WD'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Per-channel error accumulation. The final burst's response clears the channel for its next transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= '0;
    end else if (pop_s) begin
      if (head_last_s) begin
        err_r[head_ch_s] <= 1'b0;
      end else if (resp_err_s) begin
        err_r[head_ch_s] <= 1'b1;
      end
    end else if (timeout_hit_s) begin
      err_r[head_ch_s] <= 1'b1;
    end
  end

  // Completion record register. The record holds until accepted, and a new record can load as the old one leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_valid_r   <= 1'b0;
      done_channel_r <= CH_WD'(0);
      done_error_r   <= 1'b0;
    end else if (pop_s && head_last_s) begin
      done_valid_r   <= 1'b1;
      done_channel_r <= head_ch_s;
      done_error_r   <= err_r[head_ch_s] | resp_err_s;
    end else if (done_ready) begin
      done_valid_r   <= 1'b0;
    end
  end

  assign aw_issue_ready = !full_s;
  assign m_axi_bready   = bready_s;
  assign done_valid     = done_valid_r;
  assign done_channel   = done_channel_r;
  assign done_error     = done_error_r;
  assign outstanding    = count_r;

  dmac_write_response_tracker_checker #(
    .OUTSTANDING_DEPTH (OUTSTANDING_DEPTH),
    .TIMEOUT_CYCLES    (TIMEOUT_CYCLES)
  ) u_checker (
    .clk            (clk),
    .rst            (rst),
    .aw_issue_valid (aw_issue_valid),
    .aw_issue_ready (aw_issue_ready)
  );

endmodule

// File: tb/tb_dmac_write_response_tracker.sv
// Directed bench for dmac_write_response_tracker (8 channels, depth 8).
// Inputs change 1 time unit after the rising edge, and outputs are sampled in that same window.
module tb_dmac_write_response_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       aw_issue_valid;
  logic       aw_issue_ready;
  logic [2:0] aw_issue_channel;
  logic       aw_issue_last;
  logic       m_axi_bvalid;
  logic       m_axi_bready;
  logic [1:0] m_axi_bresp;
  logic       done_valid;
  logic       done_ready;
  logic [2:0] done_channel;
  logic       done_error;
  logic [3:0] outstanding;
`ifdef DMAC_WR_RESP_TIMEOUT_EN
  logic       timeout_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmac_write_response_tracker dut (
`ifdef DMAC_WR_RESP_TIMEOUT_EN
    .timeout_err      (timeout_err),
`endif
    .clk              (clk),
    .rst              (rst),
    .aw_issue_valid   (aw_issue_valid),
    .aw_issue_ready   (aw_issue_ready),
    .aw_issue_channel (aw_issue_channel),
    .aw_issue_last    (aw_issue_last),
    .m_axi_bvalid     (m_axi_bvalid),
    .m_axi_bready     (m_axi_bready),
    .m_axi_bresp      (m_axi_bresp),
    .done_valid       (done_valid),
    .done_ready       (done_ready),
    .done_channel     (done_channel),
    .done_error       (done_error),
    .outstanding      (outstanding)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] ch, input logic last);
    aw_issue_valid = 1'b1; aw_issue_channel = ch; aw_issue_last = last;
    cyc();
    aw_issue_valid = 1'b0;
  endtask

  task automatic bresp_cycle(input logic [1:0] r);
    m_axi_bvalid = 1'b1; m_axi_bresp = r;
    cyc();
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'd0;
  endtask

  task automatic test_reset();
    checks++; if (aw_issue_ready !== 1'b1) begin errors++; $display("FAIL reset_awready got %b exp 1", aw_issue_ready); end
    checks++; if (m_axi_bready !== 1'b0) begin errors++; $display("FAIL reset_bready got %b exp 0", m_axi_bready); end
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL reset_done_valid got %b exp 0", done_valid); end
    checks++; if (done_channel !== 3'd0 || done_error !== 1'b0) begin errors++; $display("FAIL reset_record got ch=%0d err=%b exp ch=0 err=0", done_channel, done_error); end
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
  endtask

  task automatic test_single();
    push(3'd3, 1'b1);
    checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL single_outst got %0d exp 1", outstanding); end
    checks++; if (m_axi_bready !== 1'b1) begin errors++; $display("FAIL single_bready got %b exp 1", m_axi_bready); end
    cyc();
    bresp_cycle(2'd0);
    checks++; if (done_valid !== 1'b1 || done_channel !== 3'd3 || done_error !== 1'b0) begin errors++; $display("FAIL single_record got v=%b ch=%0d err=%b exp v=1 ch=3 err=0", done_valid, done_channel, done_error); end
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL single_outst_after got %0d exp 0", outstanding); end
    cyc();
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL single_accept got %b exp 0", done_valid); end
  endtask

  task automatic test_multi_error();
    push(3'd5, 1'b0); push(3'd5, 1'b0); push(3'd5, 1'b1);
    checks++; if (outstanding !== 4'd3) begin errors++; $display("FAIL multi_outst got %0d exp 3", outstanding); end
    bresp_cycle(2'd0);
    bresp_cycle(2'd2);
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL multi_early_record got %b exp 0", done_valid); end
    bresp_cycle(2'd0);
    checks++; if (done_valid !== 1'b1 || done_channel !== 3'd5 || done_error !== 1'b1) begin errors++; $display("FAIL multi_record got v=%b ch=%0d err=%b exp v=1 ch=5 err=1", done_valid, done_channel, done_error); end
    cyc();
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL multi_single_record got %b exp 0", done_valid); end
    push(3'd5, 1'b1);
    bresp_cycle(2'd1);
    checks++; if (done_valid !== 1'b1 || done_channel !== 3'd5 || done_error !== 1'b0) begin errors++; $display("FAIL multi_clean got v=%b ch=%0d err=%b exp v=1 ch=5 err=0", done_valid, done_channel, done_error); end
    cyc();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) push(3'(i), 1'b1);
    checks++; if (aw_issue_ready !== 1'b0 || outstanding !== 4'd8) begin errors++; $display("FAIL fill_full got rdy=%b n=%0d exp rdy=0 n=8", aw_issue_ready, outstanding); end
    bresp_cycle(2'd0);
    checks++; if (aw_issue_ready !== 1'b1 || outstanding !== 4'd7) begin errors++; $display("FAIL fill_pop got rdy=%b n=%0d exp rdy=1 n=7", aw_issue_ready, outstanding); end
    checks++; if (done_valid !== 1'b1 || done_channel !== 3'd0) begin errors++; $display("FAIL fill_rec0 got v=%b ch=%0d exp v=1 ch=0", done_valid, done_channel); end
    aw_issue_valid = 1'b1; aw_issue_channel = 3'd0; aw_issue_last = 1'b1;
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'd0;
    cyc();
    aw_issue_valid = 1'b0; m_axi_bvalid = 1'b0;
    checks++; if (outstanding !== 4'd7 || done_channel !== 3'd1) begin errors++; $display("FAIL fill_pushpop got n=%0d ch=%0d exp n=7 ch=1", outstanding, done_channel); end
    push(3'd5, 1'b1);
    checks++; if (aw_issue_ready !== 1'b0 || outstanding !== 4'd8) begin errors++; $display("FAIL fill_refull got rdy=%b n=%0d exp rdy=0 n=8", aw_issue_ready, outstanding); end
    m_axi_bvalid = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    checks++; if (outstanding !== 4'd0 || m_axi_bready !== 1'b0) begin errors++; $display("FAIL fill_drain got n=%0d brdy=%b exp n=0 brdy=0", outstanding, m_axi_bready); end
    checks++; if (done_valid !== 1'b1 || done_channel !== 3'd5) begin errors++; $display("FAIL fill_last_rec got v=%b ch=%0d exp v=1 ch=5", done_valid, done_channel); end
    m_axi_bvalid = 1'b0;
    cyc();
  endtask

  task automatic test_record_stall();
    done_ready = 1'b0;
    push(3'd1, 1'b1); push(3'd2, 1'b1);
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'd0;
    cyc();
    checks++; if (done_valid !== 1'b1 || done_channel !== 3'd1) begin errors++; $display("FAIL stall_rec1 got v=%b ch=%0d exp v=1 ch=1", done_valid, done_channel); end
    checks++; if (m_axi_bready !== 1'b0 || outstanding !== 4'd1) begin errors++; $display("FAIL stall_bready got brdy=%b n=%0d exp brdy=0 n=1", m_axi_bready, outstanding); end
    cyc();
    checks++; if (done_channel !== 3'd1 || outstanding !== 4'd1) begin errors++; $display("FAIL stall_hold got ch=%0d n=%0d exp ch=1 n=1", done_channel, outstanding); end
    done_ready = 1'b1;
    #1;
    checks++; if (m_axi_bready !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", m_axi_bready); end
    cyc();
    m_axi_bvalid = 1'b0;
    checks++; if (done_valid !== 1'b1 || done_channel !== 3'd2 || outstanding !== 4'd0) begin errors++; $display("FAIL stall_rec2 got v=%b ch=%0d n=%0d exp v=1 ch=2 n=0", done_valid, done_channel, outstanding); end
    cyc();
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b exp 0", done_valid); end
  endtask

  task automatic test_interleave();
    push(3'd0, 1'b0); push(3'd4, 1'b1); push(3'd0, 1'b1);
    bresp_cycle(2'd0);
    bresp_cycle(2'd3);
    checks++; if (done_valid !== 1'b1 || done_channel !== 3'd4 || done_error !== 1'b1) begin errors++; $display("FAIL inter_ch4 got v=%b ch=%0d err=%b exp v=1 ch=4 err=1", done_valid, done_channel, done_error); end
    bresp_cycle(2'd0);
    checks++; if (done_valid !== 1'b1 || done_channel !== 3'd0 || done_error !== 1'b0) begin errors++; $display("FAIL inter_ch0 got v=%b ch=%0d err=%b exp v=1 ch=0 err=0", done_valid, done_channel, done_error); end
    cyc();
  endtask

  task automatic test_reset_mid();
    done_ready = 1'b0;
    push(3'd1, 1'b1); push(3'd2, 1'b0); push(3'd2, 1'b1); push(3'd6, 1'b1); push(3'd7, 1'b1);
    bresp_cycle(2'd0);
    bresp_cycle(2'd2);
    checks++; if (outstanding !== 4'd3 || done_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got n=%0d v=%b exp n=3 v=1", outstanding, done_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (aw_issue_ready !== 1'b1 || m_axi_bready !== 1'b0 || outstanding !== 4'd0) begin errors++; $display("FAIL mid_fifo got rdy=%b brdy=%b n=%0d exp 1 0 0", aw_issue_ready, m_axi_bready, outstanding); end
    checks++; if (done_valid !== 1'b0 || done_channel !== 3'd0 || done_error !== 1'b0) begin errors++; $display("FAIL mid_record got v=%b ch=%0d err=%b exp 0 0 0", done_valid, done_channel, done_error); end
    cyc();
    rst = 1'b0; done_ready = 1'b1;
    cyc();
    push(3'd2, 1'b1);
    bresp_cycle(2'd0);
    checks++; if (done_valid !== 1'b1 || done_channel !== 3'd2 || done_error !== 1'b0) begin errors++; $display("FAIL mid_err_cleared got v=%b ch=%0d err=%b exp v=1 ch=2 err=0", done_valid, done_channel, done_error); end
    cyc();
  endtask

`ifdef DMAC_WR_RESP_TIMEOUT_EN
  task automatic test_timeout();
    push(3'd6, 1'b1);
    for (int i = 0; i < 1023; i++) cyc();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", timeout_err); end
    cyc(); cyc();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag got %b exp 1", timeout_err); end
    bresp_cycle(2'd0);
    checks++; if (done_valid !== 1'b1 || done_channel !== 3'd6 || done_error !== 1'b1) begin errors++; $display("FAIL to_record got v=%b ch=%0d err=%b exp v=1 ch=6 err=1", done_valid, done_channel, done_error); end
    cyc();
  endtask
`endif

  initial begin
    rst = 1'b1;
    aw_issue_valid = 1'b0; aw_issue_channel = 3'd0; aw_issue_last = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'd0; done_ready = 1'b1;
    cyc(); cyc();
    test_reset();
    rst = 1'b0;
    cyc();
    test_single();
    test_multi_error();
    test_fill();
    test_record_stall();
    test_interleave();
    test_reset_mid();
`ifdef DMAC_WR_RESP_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
